// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the CPU instruction controller
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_UNSUP   = 3'd0,
        C_MOV_IMM = 3'd1,
        C_MOV_REG = 3'd2,
        C_ADD     = 3'd3,
        C_CMP     = 3'd4,
        C_AND     = 3'd5,
        C_MVN     = 3'd6
    } iclass_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_MDATA  = 4'b1000;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] VSEL_PC     = 4'b0010;
    localparam logic [3:0] VSEL_C      = 4'b0001;

    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] ALUOP_ADD  = 2'b00;

    function automatic iclass_e classify(input logic [2:0] opcode, input logic [1:0] op);
        iclass_e cls;
        cls = C_UNSUP;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = C_MOV_IMM;
            else if (op == OP_MOV_REG) cls = C_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = C_ADD;
                OP_CMP:  cls = C_CMP;
                OP_AND:  cls = C_AND;
                default: cls = C_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - combinational IR field split, immediate sign extension and class decode
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output iclass_e     cls
);

    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign cls    = classify(ir[15:13], ir[12:11]);

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction sequencer driving the 16-bit datapath strobes and selects
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [3:0]  vsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    iclass_e     cls;

    inst_decoder u_dec (
        .ir     (ir_q),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only loads on an accept, so it holds across the whole instruction
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    ir_d    = in;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_MOV_IMM:             state_d = S_WRITE_IMM;
                    C_ADD, C_CMP, C_AND:   state_d = S_GET_A;
                    C_MOV_REG, C_MVN:      state_d = S_GET_B;
                    default:               state_d = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = (cls == C_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        vsel     = VSEL_C;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = SHIFT_NONE;
        ALUop    = ALUOP_ADD;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_WRITE_IMM: begin
                vsel     = VSEL_SXIMM8;
                writenum = rn;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                shift = sh;
                // MOV reg is computed as 0 + B, so force A to zero and add
                if (cls == C_MOV_REG) begin
                    ALUop = ALUOP_ADD;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                end
                if (cls == C_CMP) loads = 1'b1;
                else              loadc = 1'b1;
            end
            S_WRITE_REG: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

    // memory and PC writeback paths and sximm5 operand belong to later extensions
    a_reserved_sel: assert property (@(posedge clk) disable iff (reset)
        (vsel != VSEL_MDATA) && (vsel != VSEL_PC) && !bsel);

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [3:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .in       (in),
        .w        (w),
        .vsel     (vsel),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic pw, input logic [3:0] pvs,
                                       input logic [2:0] prn, input logic [2:0] pwn,
                                       input logic pwr, input logic pla, input logic plb,
                                       input logic plc, input logic pls, input logic pas,
                                       input logic pbs, input logic [1:0] psh,
                                       input logic [1:0] pop);
        return {10'd0, pw, pvs, prn, pwn, pwr, pla, plb, plc, pls, pas, pbs, psh, pop};
    endfunction

    function automatic logic [31:0] observed();
        return pk(w, vsel, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, shift, ALUop);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference: per-cycle control words derived from what each instruction must do
    task automatic build_expect(input logic [15:0] i);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic movi, movr, aluop_cls, cmp, uses_a;
        opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
        movi      = (opc == 3'b110) && (op == 2'b10);
        movr      = (opc == 3'b110) && (op == 2'b00);
        aluop_cls = (opc == 3'b101);
        cmp       = aluop_cls && (op == 2'b01);
        uses_a    = aluop_cls && (op != 2'b11);
        exp_q.delete();
        exp_q.push_back(pk(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (movi) begin
            exp_q.push_back(pk(0, 4'b0100, 0, rn, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (movr || aluop_cls) begin
            if (uses_a)
                exp_q.push_back(pk(0, 4'b0001, rn, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(pk(0, 4'b0001, rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(pk(0, 4'b0001, 0, 0, 0, 0, 0, !cmp, cmp, movr, 0, sh,
                               movr ? 2'b00 : op));
            if (!cmp)
                exp_q.push_back(pk(0, 4'b0001, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // Called at a negedge while in WAIT; returns at the negedge where WAIT is seen again
    task automatic run_instr(input logic [15:0] i, input bit junk);
        logic [31:0] idle_w;
        logic [15:0] e8, e5;
        idle_w = pk(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e8 = 16'($signed(i[7:0]));
        e5 = 16'($signed(i[4:0]));
        build_expect(i);
        in = i;
        s  = 1'b1;
        foreach (exp_q[k]) begin
            @(negedge clk);
            check($sformatf("step%0d_%h", k, i), observed(), exp_q[k]);
            if (k == 0) begin
                check("sximm8", {16'd0, sximm8}, {16'd0, e8});
                check("sximm5", {16'd0, sximm5}, {16'd0, e5});
            end
            s  = junk ? 1'($urandom) : 1'b0;
            in = junk ? 16'($urandom) : 16'h0000;
        end
        @(negedge clk);
        check($sformatf("done_%h", i), observed(), idle_w);
        check("sximm8_hold", {16'd0, sximm8}, {16'd0, e8});
        s = 1'b0;
    endtask

    logic [31:0] idle_word;
    logic [15:0] rnd_i;
    int          r;

    initial begin
        idle_word = pk(1, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0000;
        #1;
        check("reset_out", observed(), idle_word);
        @(negedge clk);
        reset = 1'b0;
        check("reset_sx8", {16'd0, sximm8}, 32'd0);

        run_instr(16'hD007, 1'b0);
        run_instr(16'hA148, 1'b0);
        run_instr(16'hA800, 1'b1);
        run_instr(16'hD080, 1'b0);
        check("sx8_neg", {16'd0, sximm8}, 32'h0000FF80);
        run_instr(16'hD010, 1'b0);
        check("sx5_neg", {16'd0, sximm5}, 32'h0000FFF0);

        // unsupported with s held high: DECODE/WAIT alternate
        in = 16'hE000;
        s  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("unsup_hold%0d", k), {31'd0, w}, {31'd0, k[0]});
            check("unsup_nostrobe", observed() & ~32'h00200000, idle_word & ~32'h00200000);
        end
        s = 1'b0;
        @(negedge clk);

        // reset asserted while an ADD sits in ALU
        in = 16'hA148;
        s  = 1'b1;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_loadc", {31'd0, loadc}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_immediate", observed(), idle_word);
        @(negedge clk);
        reset = 1'b0;
        check("rst_held", observed(), idle_word);
        @(negedge clk);
        check("rst_wait", observed(), idle_word);
        check("rst_ir8", {16'd0, sximm8}, 32'd0);
        check("rst_ir5", {16'd0, sximm5}, 32'd0);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 9));
            rnd_i = 16'($urandom);
            if (r < 3)      rnd_i[15:13] = 3'b110;
            else if (r < 7) rnd_i[15:13] = 3'b101;
            run_instr(rnd_i, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("idle_wait", observed(), idle_word);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
